// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters.
// Optional per-requester grant counters: define ARB_GRANT_CNT_EN.
module fifo_wr_arbiter #(
  parameter int B         = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*B-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data,
  input  logic           fifo_full,
  output logic           busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [N*16-1:0] grant_cnt
`endif
);

  localparam int GW = $clog2(N);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] IDX_TOP  = GW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [N-1:0]  grant_q, grant_d;

  logic          found;
  logic [GW-1:0] win;
  logic [GW-1:0] idx;
  logic [B-1:0]  sel_data;
  logic          xfer;
  logic          rel;

  // Pick the first requester above the last winner, wrapping
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = GW'((int'(last_q) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Select the granted requester's word
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (g_q == GW'(i)) sel_data = req_data[i*B +: B];
    end
  end

  // Next-state, burst accounting and write-port outputs
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    last_d      = last_q;
    beat_d      = beat_q;
    grant_d     = grant_q;
    xfer        = 1'b0;
    rel         = 1'b0;
    ack         = '0;
    fifo_wr     = 1'b0;
    fifo_w_data = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = GRANT;
          g_d          = win;
          last_d       = win;
          beat_d       = '0;
          grant_d      = '0;
          grant_d[win] = 1'b1;
        end
      end
      GRANT: begin
        xfer        = req[g_q] & ~fifo_full;
        fifo_wr     = xfer;
        ack[g_q]    = xfer;
        fifo_w_data = sel_data;
        rel = ~req[g_q]
            | (xfer & req_last[g_q])
            | (xfer & (beat_q == BEAT_MAX));
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          beat_d  = '0;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= IDX_TOP;
      beat_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == GRANT);

`ifdef ARB_GRANT_CNT_EN
  logic [N-1:0][15:0] cnt_q, cnt_d;

  // Count grants per requester, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && found && cnt_q[win] != 16'hFFFF)
      cnt_d[win] = cnt_q[win] + 16'd1;
  end

  // Counter registers, cleared on reset
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corners,
// and random traffic against a transaction-level model.
module tb_fifo_wr_arbiter;

  localparam int B  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*B-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           fifo_wr;
  logic [B-1:0]   fifo_w_data;
  logic           busy;
`ifdef ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  fifo_wr_arbiter #(.B(B), .N(N), .MAX_BURST(MB)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .req_last(req_last),
    .ack(ack),
    .grant(grant),
    .fifo_wr(fifo_wr),
    .fifo_w_data(fifo_w_data),
    .fifo_full(fifo_full),
    .busy(busy)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the port (-1 none), who won last,
  // how many words went out in this grant, grants per requester.
  int m_owner = -1;
  int m_rr    = N - 1;
  int m_words = 0;
  int m_cnt[N];

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] lst;
    logic       fl;
    logic [3:0] g;
    logic [3:0] a;
    logic       w;
    logic       bz;
    logic [7:0] d;
  } vec_t;

  vec_t tbl[10];

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int w;
    w = -1;
    if (!reset) begin
      m_owner = -1;
      m_rr    = N - 1;
      m_words = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
      if (w >= 0) begin
        m_owner = w;
        m_rr    = w;
        m_words = 0;
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (!fifo_full) begin
      m_words++;
      if (req_last[m_owner] || m_words == MB) m_owner = -1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    logic [N-1:0] ea;
    logic         ew;
    logic [B-1:0] ed;
    @(negedge clk);
    eg = '0;
    ea = '0;
    ew = 1'b0;
    ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed = req_data[m_owner*B +: B];
      ew = req[m_owner] && !fifo_full;
      if (ew) ea[m_owner] = 1'b1;
    end
    cmp("rnd_grant", 64'(grant), 64'(eg));
    cmp("rnd_ack", 64'(ack), 64'(ea));
    cmp("rnd_wr", 64'(fifo_wr), 64'(ew));
    cmp("rnd_data", 64'(fifo_w_data), 64'(ed));
    cmp("rnd_busy", 64'(busy), 64'(m_owner >= 0));
`ifdef ARB_GRANT_CNT_EN
    for (int i = 0; i < N; i++)
      cmp("rnd_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
  endtask

  initial begin
    // rst rq lst fl | grant ack wr busy data
    tbl[0] = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 4'h4, 4'h0, 1'b0, 4'h4, 4'h4, 1'b1, 1'b1, 8'h33};
    tbl[3] = '{1'b1, 4'h4, 4'h4, 1'b0, 4'h4, 4'h4, 1'b1, 1'b1, 8'h33};
    tbl[4] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 4'h2, 4'h0, 1'b1, 4'h2, 4'h0, 1'b0, 1'b1, 8'h22};
    tbl[7] = '{1'b1, 4'h2, 4'h0, 1'b0, 4'h2, 4'h2, 1'b1, 1'b1, 8'h22};
    tbl[8] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h2, 4'h0, 1'b0, 1'b1, 8'h22};
    tbl[9] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};

    req_data = 32'h44332211;
    reset = 1'b0;
    req = 4'hF;
    cyc();

    for (int i = 0; i < 10; i++) begin
      reset     = tbl[i].rst;
      req       = tbl[i].rq;
      req_last  = tbl[i].lst;
      fifo_full = tbl[i].fl;
      @(negedge clk);
      n_cmp++;
      if (grant !== tbl[i].g || ack !== tbl[i].a ||
          fifo_wr !== tbl[i].w || busy !== tbl[i].bz ||
          fifo_w_data !== tbl[i].d) begin
        n_bad++;
        $display("FAIL vec%0d: got g=%h a=%h w=%b b=%b d=%h expected g=%h a=%h w=%b b=%b d=%h",
                 i, grant, ack, fifo_wr, busy, fifo_w_data,
                 tbl[i].g, tbl[i].a, tbl[i].w, tbl[i].bz, tbl[i].d);
      end
      cyc();
    end

    // All four requesting: bursts of 4 in order 0,1,2,3,0 with a gap
    reset = 1'b0;
    req = 4'hF;
    req_last = '0;
    fifo_full = 1'b0;
    cyc();
    reset = 1'b1;
    for (int c = 0; c < 25; c++) begin
      logic [3:0] eg;
      logic [7:0] ed;
      eg = '0;
      ed = '0;
      if (c % 5 != 0) begin
        eg[(c / 5) % 4] = 1'b1;
        ed = 8'(8'h11 * ((c / 5) % 4 + 1));
      end
      @(negedge clk);
      cmp("rr_grant", 64'(grant), 64'(eg));
      cmp("rr_wr", 64'(fifo_wr), 64'(c % 5 != 0));
      cmp("rr_data", 64'(fifo_w_data), 64'(ed));
      cyc();
    end

    // Reset in the middle of a burst at beat 2
    cyc();
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    @(negedge clk);
    cmp("mid_rst_grant", 64'(grant), 64'(0));
    cmp("mid_rst_busy", 64'(busy), 64'(0));
    cmp("mid_rst_wr", 64'(fifo_wr), 64'(0));
`ifdef ARB_GRANT_CNT_EN
    cmp("mid_rst_cnt", 64'(grant_cnt), 64'(0));
`endif

    // Requester 3 withdraws after one word; search wraps to 0
    reset = 1'b1;
    req = 4'b1000;
    cyc();
    @(negedge clk);
    cmp("wrap_g3", 64'(grant), 64'(4'b1000));
    cmp("wrap_wr", 64'(fifo_wr), 64'(1));
    cmp("wrap_d", 64'(fifo_w_data), 64'(8'h44));
    cyc();
    req = 4'b0000;
    @(negedge clk);
    cmp("wrap_drop_wr", 64'(fifo_wr), 64'(0));
    cmp("wrap_drop_g", 64'(grant), 64'(4'b1000));
    cyc();
    req = 4'b1001;
    @(negedge clk);
    cmp("wrap_idle", 64'(busy), 64'(0));
    cyc();
    @(negedge clk);
    cmp("wrap_g0", 64'(grant), 64'(4'b0001));

    // Requester 1 stalled by full for 5 cycles mid-burst
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    req = 4'b0010;
    cyc();
    @(negedge clk);
    cmp("full_first_wr", 64'(fifo_wr), 64'(1));
    cyc();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cmp("full_wr", 64'(fifo_wr), 64'(0));
      cmp("full_ack", 64'(ack), 64'(0));
      cmp("full_grant", 64'(grant), 64'(4'b0010));
      cyc();
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp("resume_wr", 64'(fifo_wr), 64'(1));
      cmp("resume_d", 64'(fifo_w_data), 64'(8'h22));
      cyc();
    end
    @(negedge clk);
    cmp("full_done_busy", 64'(busy), 64'(0));
    cmp("full_done_g", 64'(grant), 64'(0));

    // Random traffic against the model
    reset = 1'b0;
    cyc();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) != 0);
      req       = 4'($urandom) | 4'($urandom);
      req_last  = 4'($urandom) & 4'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      req_data  = $urandom;
      check_model();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
